conv_in_data_unpackage: RTL and testbench



---
 rtl/cnn_stream_pkg.sv | 25 ++
 rtl/conv_in_data_unpackage.sv | 112 +++++++++++
 tb/tb_conv_in_data_unpackage.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared definitions for the 32-bit feature-map stream packer/unpacker pair.
package cnn_stream_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned MAX_WORDS = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_HOLD = 2'd2
  } stream_state_e;

  // ceil(size/32) with 0 treated as one word and a clamp at MAX_WORDS
  function automatic logic [3:0] words_per_vec(input logic [11:0] size);
    if (size == 12'd0) return 4'd1;
    if (size >= 12'd256) return 4'(MAX_WORDS);
    return {1'b0, size[7:5]} + {3'b000, |size[4:0]};
  endfunction

  function automatic logic [WORD_W-1:0] chan_tail_mask(input logic [4:0] rem);
    if (rem == 5'd0) return '1;
    return (32'd1 << rem) - 32'd1;
  endfunction

endpackage

// File: rtl/conv_in_data_unpackage.sv
// Packs 32-bit stream beats into one 256-bit channel vector per pixel and
// hands it to the MAC array over a valid/ready handshake.
module conv_in_data_unpackage
  import cnn_stream_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned VEC_WIDTH            = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            layer_start,
  input  logic [11:0]                     input_channel_size,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_last,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] in_data,
  output logic                            vec_valid,
  input  logic                            vec_ready,
  output logic [VEC_WIDTH-1:0]            vec_data,
  output logic                            vec_last,
  output logic                            layer_done,
  output logic                            frame_err
);

  stream_state_e          state_q, state_d;
  logic [2:0]             word_cnt_q, word_cnt_d;
  logic [3:0]             wpv_q, wpv_d;
  logic [WORD_W-1:0]      tail_mask_q, tail_mask_d;
  logic [VEC_WIDTH-1:0]   vec_data_q, vec_data_d;
  logic                   vec_last_q, vec_last_d;
  logic                   layer_done_q, layer_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   last_word;

  assign last_word = ({1'b0, word_cnt_q} + 4'd1) == wpv_q;

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    wpv_d        = wpv_q;
    tail_mask_d  = tail_mask_q;
    vec_data_d   = vec_data_q;
    vec_last_d   = vec_last_q;
    layer_done_d = 1'b0;
    frame_err_d  = frame_err_q;

    case (state_q)
      S_IDLE: begin
        if (layer_start) begin
          state_d     = S_FILL;
          word_cnt_d  = '0;
          wpv_d       = words_per_vec(input_channel_size);
          tail_mask_d = (input_channel_size >= 12'd256) ? '1
                                                        : chan_tail_mask(input_channel_size[4:0]);
        end
      end
      S_FILL: begin
        if (in_valid) begin
          vec_data_d[{word_cnt_q, 5'd0} +: WORD_W] = last_word ? (in_data & tail_mask_q) : in_data;
          if (last_word || in_last) begin
            // An in_last before the vector is full closes it early and is a framing error
            state_d     = S_HOLD;
            word_cnt_d  = '0;
            vec_last_d  = in_last;
            frame_err_d = frame_err_q | (in_last & ~last_word);
          end else begin
            word_cnt_d = word_cnt_q + 3'd1;
          end
        end
      end
      S_HOLD: begin
        if (vec_ready) begin
          vec_data_d   = '0;
          vec_last_d   = 1'b0;
          layer_done_d = vec_last_q;
          state_d      = vec_last_q ? S_IDLE : S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_cnt_q   <= '0;
      wpv_q        <= 4'd1;
      tail_mask_q  <= '1;
      vec_data_q   <= '0;
      vec_last_q   <= 1'b0;
      layer_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      wpv_q        <= wpv_d;
      tail_mask_q  <= tail_mask_d;
      vec_data_q   <= vec_data_d;
      vec_last_q   <= vec_last_d;
      layer_done_q <= layer_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign in_ready   = (state_q == S_FILL);
  assign vec_valid  = (state_q == S_HOLD);
  assign vec_data   = vec_data_q;
  assign vec_last   = vec_last_q;
  assign layer_done = layer_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_conv_in_data_unpackage.sv
// Directed plus randomized bench for conv_in_data_unpackage against a channel-level model.
module tb_conv_in_data_unpackage;

  logic         clk = 1'b0;
  logic         rst;
  logic         layer_start;
  logic [11:0]  input_channel_size;
  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  logic [31:0]  in_data;
  logic         vec_valid;
  logic         vec_ready;
  logic [255:0] vec_data;
  logic         vec_last;
  logic         layer_done;
  logic         frame_err;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] bw [8];

  always #5 clk = ~clk;

  conv_in_data_unpackage #(
    .C_S_AXIS_TDATA_WIDTH(32),
    .VEC_WIDTH(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .layer_start(layer_start),
    .input_channel_size(input_channel_size),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_last(in_last),
    .in_data(in_data),
    .vec_valid(vec_valid),
    .vec_ready(vec_ready),
    .vec_data(vec_data),
    .vec_last(vec_last),
    .layer_done(layer_done),
    .frame_err(frame_err)
  );

  // Model: channel i is present when its word was sent and i is below the kept channel count
  function automatic logic [255:0] exp_vec(input int size, input int nsent);
    logic [255:0] v;
    int limit;
    v = '0;
    limit = (size == 0) ? 32 : ((size >= 256) ? 256 : size);
    for (int i = 0; i < 256; i++)
      if (i < limit && (i / 32) < nsent) v[i] = bw[i / 32][i % 32];
    return v;
  endfunction

  function automatic int exp_wpv(input int size);
    if (size == 0) return 1;
    if (size >= 256) return 8;
    return (size + 31) / 32;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int size);
    input_channel_size = 12'(size);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
    chk("start_in_ready", in_ready, 1);
  endtask

  task automatic run_vector(input int size, input int nsend, input bit last, input int stall);
    for (int w = 0; w < nsend; w++) begin
      in_valid = 1'b1;
      in_data  = bw[w];
      in_last  = last && (w == nsend - 1);
      chk("fill_in_ready", in_ready, 1);
      chk("fill_no_vec_valid", vec_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("vec_valid", vec_valid, 1);
    chk("vec_data", vec_data, exp_vec(size, nsend));
    chk("vec_last", vec_last, last);
    for (int s = 0; s < stall; s++) begin
      in_valid  = 1'b1;
      in_data   = $urandom;
      vec_ready = 1'b0;
      tick();
      chk("stall_in_ready", in_ready, 0);
      chk("stall_vec_valid", vec_valid, 1);
      chk("stall_vec_data", vec_data, exp_vec(size, nsend));
      chk("stall_vec_last", vec_last, last);
    end
    in_valid  = 1'b0;
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("hs_vec_valid", vec_valid, 0);
    chk("hs_vec_data_clr", vec_data, 0);
    chk("hs_layer_done", layer_done, last);
    chk("hs_next_state", in_ready, !last);
  endtask

  initial begin
    int size;
    int nv;
    rst = 1'b1;
    layer_start = 1'b0;
    input_channel_size = '0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    vec_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_vec_valid", vec_valid, 0);
    chk("rst_vec_data", vec_data, 0);
    chk("rst_vec_last", vec_last, 0);
    chk("rst_layer_done", layer_done, 0);
    chk("rst_frame_err", frame_err, 0);

    // Full 256-channel vector
    for (int i = 0; i < 8; i++) bw[i] = 32'(i + 1);
    start_layer(256);
    run_vector(256, 8, 1'b1, 0);
    tick();
    chk("s256_done_one_cycle", layer_done, 0);
    chk("s256_idle", in_ready, 0);

    // Tail mask on 40 channels
    bw[0] = 32'hFFFF_FFFF;
    bw[1] = 32'hFFFF_FFFF;
    start_layer(40);
    run_vector(40, 2, 1'b1, 0);
    tick();

    // Back-pressure on the first of two vectors
    start_layer(64);
    for (int i = 0; i < 2; i++) bw[i] = $urandom;
    run_vector(64, 2, 1'b0, 5);
    for (int i = 0; i < 2; i++) bw[i] = $urandom;
    run_vector(64, 2, 1'b1, 0);
    tick();

    // size 0 keeps whole single words
    start_layer(0);
    bw[0] = 32'hA5A5_A5A5;
    run_vector(0, 1, 1'b0, 0);
    bw[0] = $urandom;
    run_vector(0, 1, 1'b0, 1);
    bw[0] = $urandom;
    run_vector(0, 1, 1'b1, 0);
    tick();

    // size above 256 clamps to 8 beats
    start_layer(300);
    for (int i = 0; i < 8; i++) bw[i] = $urandom;
    run_vector(300, 8, 1'b0, 0);
    for (int i = 0; i < 8; i++) bw[i] = $urandom;
    run_vector(300, 8, 1'b1, 2);
    tick();

    // Randomized layers
    for (int l = 0; l < 10; l++) begin
      size = $urandom_range(0, 400);
      nv = $urandom_range(1, 3);
      start_layer(size);
      for (int v = 0; v < nv; v++) begin
        for (int i = 0; i < 8; i++) bw[i] = $urandom;
        run_vector(size, exp_wpv(size), v == nv - 1, $urandom_range(0, 2));
      end
      tick();
      chk("rand_done_one_cycle", layer_done, 0);
    end
    chk("no_frame_err_yet", frame_err, 0);

    // Early in_last
    start_layer(96);
    for (int i = 0; i < 8; i++) bw[i] = $urandom;
    run_vector(96, 2, 1'b1, 0);
    chk("early_frame_err", frame_err, 1);
    tick();
    chk("frame_err_sticky", frame_err, 1);

    // Reset in the middle of a vector
    start_layer(256);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_vec_valid", vec_valid, 0);
    chk("mid_rst_vec_data", vec_data, 0);
    chk("mid_rst_vec_last", vec_last, 0);
    chk("mid_rst_layer_done", layer_done, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      tick();
      chk("idle_no_accept", in_ready, 0);
      chk("idle_no_vec", vec_valid, 0);
    end
    in_valid = 1'b0;
    start_layer(64);
    for (int i = 0; i < 8; i++) bw[i] = $urandom;
    run_vector(64, 2, 1'b1, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
